// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file for the MIPS datapath with a per-register busy scoreboard.
// Decode reads two operands combinationally and issues destinations (busy_set).
// Writeback stores results (reg_write) and retires the matching busy bit.
// Decode uses busy_1/busy_2 to detect RAW hazards on results still in flight.
//
// Parameters
//   DATA_W   : register width in bits
//   ADDR_W   : register index width, DEPTH = 2**ADDR_W
//   ZERO_REG : 1 -> register 0 reads 0, ignores writes, is never marked busy
//   BYPASS   : 1 -> a same-cycle write is forwarded to the read ports, and
//              the forwarded port reports not-busy
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   reg_write/write_reg/
//   write_data               writeback port (stores data, clears busy)
//   read_reg_1/read_reg_2    read indices
//   out_data_1/out_data_2    read data (combinational)
//   busy_set/busy_reg        issue port (marks destination busy)
//   busy_1/busy_2            read index has an outstanding producer
//   busy_any                 registered OR of all busy bits
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_reg,
    output logic              busy_1,
    output logic              busy_2,
    output logic              busy_any
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              busy_any_q;
    logic              busy_any_d;

    logic wr_en;
    logic set_en;
    logic zero_1;
    logic zero_2;
    logic fwd_1;
    logic fwd_2;

    // Qualified strobes: register 0 is inert when hard-wired to zero.
    // Forwarding is gated by rst so that, while reset is held, the read
    // ports show the reset contents rather than a write that will be dropped.
    always_comb begin
        wr_en  = reg_write && !((ZERO_REG != 0) && (write_reg == '0));
        set_en = busy_set  && !((ZERO_REG != 0) && (busy_reg  == '0));
        zero_1 = (ZERO_REG != 0) && (read_reg_1 == '0);
        zero_2 = (ZERO_REG != 0) && (read_reg_2 == '0);
        fwd_1  = (BYPASS != 0) && rst && wr_en && (write_reg == read_reg_1);
        fwd_2  = (BYPASS != 0) && rst && wr_en && (write_reg == read_reg_2);
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[write_reg] = write_data;
        end
    end

    // Clear first, then set: when writeback and issue hit the same index the
    // newer producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (reg_write) begin
            busy_d[write_reg] = 1'b0;
        end
        if (set_en) begin
            busy_d[busy_reg] = 1'b1;
        end
        busy_any_d = |busy_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
            busy_q     <= '0;
            busy_any_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_any_q <= busy_any_d;
        end
    end

    // Read ports: zero register has the last word over any forwarding.
    always_comb begin
        out_data_1 = regs_q[read_reg_1];
        busy_1     = busy_q[read_reg_1];
        if (fwd_1) begin
            out_data_1 = write_data;
            busy_1     = 1'b0;
        end
        if (zero_1) begin
            out_data_1 = '0;
            busy_1     = 1'b0;
        end
    end

    always_comb begin
        out_data_2 = regs_q[read_reg_2];
        busy_2     = busy_q[read_reg_2];
        if (fwd_2) begin
            out_data_2 = write_data;
            busy_2     = 1'b0;
        end
        if (zero_2) begin
            out_data_2 = '0;
            busy_2     = 1'b0;
        end
    end

    assign busy_any = busy_any_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    typedef struct {
        bit          rst;
        bit          we;
        int          wr;
        logic [31:0] wd;
        int          r1;
        int          r2;
        bit          bs;
        int          br;
    } in_t;

    typedef struct {
        int          id;
        in_t         v;
        logic [31:0] d1;
        logic [31:0] d2;
        bit          b1;
        bit          b2;
        bit          ba;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: defaults (32-bit, 32 regs, zero reg, bypass)
    logic        a_rst, a_reg_write, a_busy_set, a_busy_1, a_busy_2, a_busy_any;
    logic [4:0]  a_write_reg, a_read_reg_1, a_read_reg_2, a_busy_reg;
    logic [31:0] a_write_data, a_out_data_1, a_out_data_2;

    // DUT B: 16-bit, 8 regs, no zero reg, no bypass
    logic        b_rst, b_reg_write, b_busy_set, b_busy_1, b_busy_2, b_busy_any;
    logic [2:0]  b_write_reg, b_read_reg_1, b_read_reg_2, b_busy_reg;
    logic [15:0] b_write_data, b_out_data_1, b_out_data_2;

    regfile_scoreboard u_a (
        .clk(clk), .rst(a_rst), .reg_write(a_reg_write), .write_reg(a_write_reg),
        .write_data(a_write_data), .read_reg_1(a_read_reg_1), .read_reg_2(a_read_reg_2),
        .out_data_1(a_out_data_1), .out_data_2(a_out_data_2), .busy_set(a_busy_set),
        .busy_reg(a_busy_reg), .busy_1(a_busy_1), .busy_2(a_busy_2), .busy_any(a_busy_any)
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(b_rst), .reg_write(b_reg_write), .write_reg(b_write_reg),
        .write_data(b_write_data), .read_reg_1(b_read_reg_1), .read_reg_2(b_read_reg_2),
        .out_data_1(b_out_data_1), .out_data_2(b_out_data_2), .busy_set(b_busy_set),
        .busy_reg(b_busy_reg), .busy_1(b_busy_1), .busy_2(b_busy_2), .busy_any(b_busy_any)
    );

    // Reference model: plain storage plus a set of pending destinations.
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];
    int          NREG [2] = '{32, 8};
    bit          ZR   [2] = '{1'b1, 1'b0};
    bit          BP   [2] = '{1'b1, 1'b0};
    logic [31:0] MASK [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t IDLE();
        in_t v;
        v = '{rst: 1'b1, we: 1'b0, wr: 0, wd: 32'h0, r1: 0, r2: 0, bs: 1'b0, br: 0};
        return v;
    endfunction

    function automatic vec_t V(int id, bit rst, bit we, int wr, logic [31:0] wd,
                               int r1, int r2, bit bs, int br,
                               logic [31:0] d1, logic [31:0] d2, bit b1, bit b2, bit ba);
        vec_t t;
        t.id = id;
        t.v  = '{rst: rst, we: we, wr: wr, wd: wd, r1: r1, r2: r2, bs: bs, br: br};
        t.d1 = d1; t.d2 = d2; t.b1 = b1; t.b2 = b2; t.ba = ba;
        return t;
    endfunction

    task automatic m_reset(input int id);
        for (int i = 0; i < 32; i++) begin
            m_mem[id][i]  = 32'(i);
            m_busy[id][i] = 1'b0;
        end
    endtask

    task automatic m_update(input int id, input in_t v);
        if (!v.rst) begin
            m_reset(id);
        end else begin
            if (v.we && !(ZR[id] && v.wr == 0)) m_mem[id][v.wr] = v.wd & MASK[id];
            if (v.we) m_busy[id][v.wr] = 1'b0;
            if (v.bs && !(ZR[id] && v.br == 0)) m_busy[id][v.br] = 1'b1;
        end
    endtask

    task automatic predict(input int id, input in_t v, input int rr,
                           output logic [31:0] d, output bit b);
        if (!v.rst) begin
            d = 32'(rr); b = 1'b0;
        end else if (ZR[id] && rr == 0) begin
            d = 32'h0; b = 1'b0;
        end else if (BP[id] && v.we && v.wr == rr && !(ZR[id] && v.wr == 0)) begin
            d = v.wd & MASK[id]; b = 1'b0;
        end else begin
            d = m_mem[id][rr]; b = m_busy[id][rr];
        end
    endtask

    function automatic bit pred_any(input int id, input in_t v);
        bit any = 1'b0;
        for (int i = 0; i < NREG[id]; i++) any |= m_busy[id][i];
        return v.rst ? any : 1'b0;
    endfunction

    task automatic get_act(input int id, output logic [31:0] a1, output logic [31:0] a2,
                           output logic ab1, output logic ab2, output logic aba);
        if (id == 0) begin
            a1 = a_out_data_1; a2 = a_out_data_2;
            ab1 = a_busy_1; ab2 = a_busy_2; aba = a_busy_any;
        end else begin
            a1 = {16'h0, b_out_data_1}; a2 = {16'h0, b_out_data_2};
            ab1 = b_busy_1; ab2 = b_busy_2; aba = b_busy_any;
        end
    endtask

    task automatic drive(input in_t va, input in_t vb);
        a_rst = va.rst; a_reg_write = va.we; a_write_reg = 5'(va.wr); a_write_data = va.wd;
        a_read_reg_1 = 5'(va.r1); a_read_reg_2 = 5'(va.r2);
        a_busy_set = va.bs; a_busy_reg = 5'(va.br);
        b_rst = vb.rst; b_reg_write = vb.we; b_write_reg = 3'(vb.wr); b_write_data = vb.wd[15:0];
        b_read_reg_1 = 3'(vb.r1); b_read_reg_2 = 3'(vb.r2);
        b_busy_set = vb.bs; b_busy_reg = 3'(vb.br);
    endtask

    task automatic chk_model(input int id, input in_t v);
        logic [31:0] e1, e2, a1, a2;
        bit eb1, eb2;
        logic ab1, ab2, aba;
        predict(id, v, v.r1, e1, eb1);
        predict(id, v, v.r2, e2, eb2);
        get_act(id, a1, a2, ab1, ab2, aba);
        cmp($sformatf("model%0d.out_data_1[r%0d]", id, v.r1), a1, e1);
        cmp($sformatf("model%0d.out_data_2[r%0d]", id, v.r2), a2, e2);
        cmp($sformatf("model%0d.busy_1[r%0d]", id, v.r1), 32'(ab1), 32'(eb1));
        cmp($sformatf("model%0d.busy_2[r%0d]", id, v.r2), 32'(ab2), 32'(eb2));
        cmp($sformatf("model%0d.busy_any", id), 32'(aba), 32'(pred_any(id, v)));
    endtask

    // Drive, settle, compare against the model (between edges).
    task automatic apply(input in_t va, input in_t vb);
        drive(va, vb);
        #1;
        chk_model(0, va);
        chk_model(1, vb);
    endtask

    task automatic tick(input in_t va, input in_t vb);
        @(posedge clk);
        m_update(0, va);
        m_update(1, vb);
        #1;
    endtask

    function automatic in_t rand_in(input int id);
        in_t v;
        int n = NREG[id];
        v.rst = ($urandom_range(0, 63) != 0);
        v.we  = $urandom_range(0, 1) == 1;
        v.bs  = $urandom_range(0, 9) < 4;
        v.wd  = $urandom;
        v.wr  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, n - 1);
        v.br  = ($urandom_range(0, 5) == 0) ? v.wr : $urandom_range(0, n - 1);
        v.r1  = ($urandom_range(0, 3) == 0) ? v.wr : $urandom_range(0, n - 1);
        v.r2  = ($urandom_range(0, 3) == 0) ? v.br : $urandom_range(0, n - 1);
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        in_t va, vb;
        logic [31:0] a1, a2;
        logic ab1, ab2, aba;

        // id, rst, we, wr, wd, r1, r2, bs, br  ->  d1, d2, b1, b2, any
        tbl.push_back(V(0,1,0, 0,32'h0,        7, 0,0, 0, 32'h7,        32'h0,        0,0,0));
        tbl.push_back(V(0,1,1, 5,32'hDEADBEEF, 5, 6,0, 0, 32'hDEADBEEF, 32'h6,        0,0,0));
        tbl.push_back(V(0,1,0, 0,32'h0,        5, 0,0, 0, 32'hDEADBEEF, 32'h0,        0,0,0));
        tbl.push_back(V(0,1,1, 0,32'h1234,     0, 0,1, 0, 32'h0,        32'h0,        0,0,0));
        tbl.push_back(V(0,1,0, 0,32'h0,        0, 0,0, 0, 32'h0,        32'h0,        0,0,0));
        tbl.push_back(V(0,1,0, 0,32'h0,        9, 9,1, 9, 32'h9,        32'h9,        0,0,0));
        tbl.push_back(V(0,1,0, 0,32'h0,        9, 3,0, 0, 32'h9,        32'h3,        1,0,1));
        tbl.push_back(V(0,1,1, 9,32'h55,       9, 9,0, 0, 32'h55,       32'h55,       0,0,1));
        tbl.push_back(V(0,1,0, 0,32'h0,        9, 9,0, 0, 32'h55,       32'h55,       0,0,0));
        tbl.push_back(V(0,1,1,12,32'hAA,      12,12,1,12, 32'hAA,       32'hAA,       0,0,0));
        tbl.push_back(V(0,1,0, 0,32'h0,       12,12,0, 0, 32'hAA,       32'hAA,       1,1,1));
        tbl.push_back(V(0,1,1, 4,32'h44,       3, 4,1, 3, 32'h3,        32'h44,       0,0,1));
        tbl.push_back(V(0,1,0, 0,32'h0,        3, 4,0, 0, 32'h3,        32'h44,       1,0,1));
        tbl.push_back(V(0,1,1,12,32'h77,      12, 3,0, 0, 32'h77,       32'h3,        0,1,1));
        tbl.push_back(V(0,1,1, 3,32'h33,      12, 3,0, 0, 32'h77,       32'h33,       0,0,1));
        tbl.push_back(V(0,1,0, 0,32'h0,       12, 3,0, 0, 32'h77,       32'h33,       0,0,0));
        tbl.push_back(V(0,1,0, 0,32'h0,       20,20,1,20, 32'h14,       32'h14,       0,0,0));
        tbl.push_back(V(0,1,0, 0,32'h0,       20,20,1,20, 32'h14,       32'h14,       1,1,1));
        tbl.push_back(V(0,1,1,20,32'h2020,    20,20,0, 0, 32'h2020,     32'h2020,     0,0,1));
        tbl.push_back(V(0,1,0, 0,32'h0,       20,20,0, 0, 32'h2020,     32'h2020,     0,0,0));
        tbl.push_back(V(1,1,0, 0,32'h0,        6, 6,0, 0, 32'h6,        32'h6,        0,0,0));
        tbl.push_back(V(1,1,1, 7,32'hFFFF,     7, 7,0, 0, 32'h7,        32'h7,        0,0,0));
        tbl.push_back(V(1,1,0, 0,32'h0,        7, 7,0, 0, 32'hFFFF,     32'hFFFF,     0,0,0));
        tbl.push_back(V(1,1,1, 0,32'h1234,     0, 0,1, 0, 32'h0,        32'h0,        0,0,0));
        tbl.push_back(V(1,1,0, 0,32'h0,        0, 0,0, 0, 32'h1234,     32'h1234,     1,1,1));
        tbl.push_back(V(1,1,1, 2,32'h2222,     2, 0,1, 2, 32'h2,        32'h1234,     0,1,1));
        tbl.push_back(V(1,1,0, 0,32'h0,        2, 0,0, 0, 32'h2222,     32'h1234,     1,1,1));
        tbl.push_back(V(1,1,1, 2,32'h3333,     2, 2,0, 0, 32'h2222,     32'h2222,     1,1,1));
        tbl.push_back(V(1,1,1, 0,32'h0,        2, 0,0, 0, 32'h3333,     32'h1234,     0,1,1));
        tbl.push_back(V(1,1,0, 0,32'h0,        0, 2,0, 0, 32'h0,        32'h3333,     0,0,0));

        // Power-on reset held across two edges.
        va = IDLE(); va.rst = 1'b0;
        vb = va;
        drive(va, vb);
        repeat (2) @(posedge clk);
        #1;
        m_reset(0);
        m_reset(1);

        foreach (tbl[k]) begin
            va = IDLE();
            vb = IDLE();
            if (tbl[k].id == 0) va = tbl[k].v;
            else                vb = tbl[k].v;
            apply(va, vb);
            get_act(tbl[k].id, a1, a2, ab1, ab2, aba);
            cmp($sformatf("vec%0d.out_data_1", k), a1, tbl[k].d1);
            cmp($sformatf("vec%0d.out_data_2", k), a2, tbl[k].d2);
            cmp($sformatf("vec%0d.busy_1", k), 32'(ab1), 32'(tbl[k].b1));
            cmp($sformatf("vec%0d.busy_2", k), 32'(ab2), 32'(tbl[k].b2));
            cmp($sformatf("vec%0d.busy_any", k), 32'(aba), 32'(tbl[k].ba));
            tick(va, vb);
        end

        // Reset asserted mid-run: contents snap back with no edge, and the
        // write/issue presented during reset are discarded.
        vb = IDLE();
        va = IDLE(); va.we = 1; va.wr = 7; va.wd = 32'hCAFE; va.bs = 1; va.br = 7;
        va.r1 = 7; va.r2 = 8;
        apply(va, vb);
        cmp("rst_seq.fwd_data", a_out_data_1, 32'hCAFE);
        tick(va, vb);
        va = IDLE(); va.r1 = 7; va.r2 = 8;
        apply(va, vb);
        cmp("rst_seq.pre_busy_1", 32'(a_busy_1), 32'h1);
        cmp("rst_seq.pre_busy_any", 32'(a_busy_any), 32'h1);
        tick(va, vb);
        va = IDLE(); va.rst = 0; va.we = 1; va.wr = 7; va.wd = 32'hBAD; va.bs = 1; va.br = 8;
        va.r1 = 7; va.r2 = 0;
        apply(va, vb);
        cmp("rst_seq.async_data_1", a_out_data_1, 32'h7);
        cmp("rst_seq.async_data_2", a_out_data_2, 32'h0);
        cmp("rst_seq.async_busy_1", 32'(a_busy_1), 32'h0);
        cmp("rst_seq.async_busy_2", 32'(a_busy_2), 32'h0);
        cmp("rst_seq.async_busy_any", 32'(a_busy_any), 32'h0);
        tick(va, vb);
        va = IDLE(); va.r1 = 7; va.r2 = 8;
        apply(va, vb);
        cmp("rst_seq.post_data_1", a_out_data_1, 32'h7);
        cmp("rst_seq.post_busy_2", 32'(a_busy_2), 32'h0);
        cmp("rst_seq.post_busy_any", 32'(a_busy_any), 32'h0);
        tick(va, vb);

        // Randomised traffic on both instances against the model.
        for (int c = 0; c < 400; c++) begin
            va = rand_in(0);
            vb = rand_in(1);
            apply(va, vb);
            tick(va, vb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
